// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding and default address width.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 13;
endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant decision for two requesters; on a tie the requester that was not granted last wins.
module mem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);
  assign valid = req0 | req1;
  assign grant = (req0 && req1) ? ~last : req1;
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single synchronous RAM port: IDLE -> ISSUE -> RESP, one access per 2 cycles.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to requester 0.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dataIn,
  output logic              mem_write,
  output logic              mem_strobe,
  input  logic [7:0]        mem_dataOut
);
  state_t     state;
  logic       win;
  logic       last;
  logic       gnt;
  logic       gnt_vld;
  logic       arb_en;
  logic [7:0] rdata_q;

  // Requests are only looked at outside ISSUE, so a req held across its own ack is a new request.
  assign arb_en = (state != ISSUE);

  mem_arb_pick u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .grant (gnt),
    .valid (gnt_vld)
  );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                last_q <= 1'b1;
    else if (arb_en && gnt_vld)  last_q <= gnt;
  end
  assign last = last_q;
`else
  // Pinning last to 1 makes the picker award every tie to requester 0.
  assign last = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      win        <= 1'b0;
      mem_addr   <= '0;
      mem_dataIn <= '0;
      mem_write  <= 1'b0;
      mem_strobe <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mem_strobe <= 1'b0;
      mem_write  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (state == RESP) rdata_q <= mem_dataOut;
          if (gnt_vld) begin
            win        <= gnt;
            mem_addr   <= gnt ? addr1 : addr0;
            mem_dataIn <= gnt ? wdata1 : wdata0;
            mem_write  <= gnt ? we1 : we0;
            mem_strobe <= 1'b1;
            ack0       <= ~gnt;
            ack1       <= gnt;
            state      <= ISSUE;
          end else begin
            state      <= IDLE;
          end
        end
        ISSUE: begin
          done0 <= ~win;
          done1 <= win;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM data arrives in RESP; outside it the last captured value is held.
  assign rdata = (state == RESP) ? mem_dataOut : rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a timing/memory reference model.
module tb_mem_arbiter;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [7:0]    wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, done0, done1, mem_write, mem_strobe;
  logic [7:0]    rdata, mem_dataIn;
  logic [7:0]    mem_dataOut = '0;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_write(mem_write),
    .mem_strobe(mem_strobe), .mem_dataOut(mem_dataOut)
  );

  // Synchronous RAM on the memory port (environment, not the reference).
  logic [7:0] ram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = 8'(i * 7 + 3);
    ram[13'h0123] = 8'h5A;
    forever begin
      @(posedge clk);
      if (mem_strobe) begin
        mem_dataOut <= ram[mem_addr];
        if (mem_write) ram[mem_addr] = mem_dataIn;
      end
    end
  end

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a shadow memory plus the timing rules (grant at edge E,
  // ack in the next cycle, done the cycle after, requests ignored while an ack shows).
  logic [7:0]    ref_mem [0:(1<<AW)-1];
  bit            m_issue, m_last, m_pw, m_prd;
  logic [7:0]    m_pval;
  logic [AW-1:0] m_paddr;
  logic [5:0]    e_ctl;   // {ack0, ack1, done0, done1, strobe, write}
  logic [AW-1:0] e_addr, e_rdaddr;
  logic [7:0]    e_din, e_rd;
  bit            e_chkrd, e_chkdin;
  int            alt_addr = -1;
  logic [7:0]    alt_val;
  int            n_ack0 = 0, n_ack1 = 0, n_wr = 0, cyc_n = 0, last_strb = 0, strb_gap = 0;

  task automatic model();
    bit w, we;
    e_ctl = '0; e_chkrd = 0; e_chkdin = 0;
    if (m_issue) begin
      e_ctl[m_pw ? 2 : 3] = 1'b1;
      e_chkrd = m_prd; e_rd = m_pval; e_rdaddr = m_paddr;
      m_issue = 0;
    end else if (req0 || req1) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      w = (req0 && req1) ? !m_last : !req0;
`else
      w = !req0;
`endif
      m_last = w;
      we = w ? we1 : we0;
      e_ctl[w ? 4 : 5] = 1'b1;
      e_ctl[1] = 1'b1;
      e_ctl[0] = we;
      e_addr = w ? addr1 : addr0;
      e_din = w ? wdata1 : wdata0;
      e_chkdin = we;
      if (we) ref_mem[e_addr] = e_din;
      else    m_pval = ref_mem[e_addr];
      m_prd = !we; m_paddr = e_addr; m_pw = w; m_issue = 1;
    end
  endtask

  task automatic check();
    logic [7:0] exp_rd;
    cyc_n++;
    chk("ctl", 32'({ack0, ack1, done0, done1, mem_strobe, mem_write}), 32'(e_ctl));
    if (e_ctl[1]) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_chkdin) chk("mem_dataIn", 32'(mem_dataIn), 32'(e_din));
    if (e_chkrd) begin
      exp_rd = (int'(e_rdaddr) == alt_addr && rdata == alt_val) ? alt_val : e_rd;
      chk("rdata", 32'(rdata), 32'(exp_rd));
    end
    n_ack0 += int'(ack0); n_ack1 += int'(ack1); n_wr += int'(mem_write);
    if (mem_strobe) begin strb_gap = cyc_n - last_strb; last_strb = cyc_n; end
  endtask

  task automatic cyc(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [7:0] d0,
                     input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(posedge clk);
    model();
    @(negedge clk);
    check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  bit            on [2];
  bit            rwe [2];
  logic [AW-1:0] ra [2];
  logic [7:0]    rd [2];
  int            s0, s1, w_before;
  logic [7:0]    prior;

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 8'(i * 7 + 3);
    ref_mem[13'h0123] = 8'h5A;
    m_issue = 0; m_last = 1; e_ctl = '0;

    @(negedge clk);
    chk("rst_ctl", 32'({ack0, ack1, done0, done1, mem_strobe, mem_write}), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_din", 32'(mem_dataIn), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    reset_n = 1'b1;

    // Tie held continuously from reset.
    s0 = n_ack0; s1 = n_ack1;
    for (int i = 0; i < 8; i++) cyc(1, 0, 13'(i), '0, 1, 0, 13'(i + 100), '0);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    chk("tie_ack0", 32'(n_ack0 - s0), 32'd2);
    chk("tie_ack1", 32'(n_ack1 - s1), 32'd2);
`else
    chk("tie_ack0", 32'(n_ack0 - s0), 32'd4);
    chk("tie_ack1", 32'(n_ack1 - s1), 32'd0);
`endif
    idle(1);

    // Single read.
    cyc(1, 0, 13'h0123, '0, 0, 0, '0, '0);
    chk("rd_ack0", 32'(ack0), 32'd1);
    cyc(0, 0, '0, '0, 0, 0, '0, '0);
    chk("rd_done0", 32'(done0), 32'd1);
    chk("rd_5a", 32'(rdata), 32'h5A);
    idle(1);

    // Write then read 0x1FFF from requester 1.
    w_before = n_wr;
    cyc(0, 0, '0, '0, 1, 1, 13'h1FFF, 8'hC3);
    cyc(0, 0, '0, '0, 0, 0, '0, '0);
    cyc(0, 0, '0, '0, 1, 0, 13'h1FFF, '0);
    cyc(0, 0, '0, '0, 0, 0, '0, '0);
    chk("wr_done1", 32'(done1), 32'd1);
    chk("wr_rd_c3", 32'(rdata), 32'hC3);
    chk("wr_pulses", 32'(n_wr - w_before), 32'd1);
    idle(1);

    // Back-to-back: req0 reasserted in the RESP cycle.
    cyc(1, 0, 13'h0010, '0, 0, 0, '0, '0);
    cyc(0, 0, '0, '0, 0, 0, '0, '0);
    cyc(1, 0, 13'h0011, '0, 0, 0, '0, '0);
    chk("b2b_gap", 32'(strb_gap), 32'd2);
    idle(2);

    // Withdrawn request: req1 pulses only during req0's ISSUE cycle.
    s1 = n_ack1;
    cyc(1, 0, 13'h0020, '0, 0, 0, '0, '0);
    cyc(0, 0, '0, '0, 1, 1, 13'h0021, 8'hEE);
    cyc(0, 0, '0, '0, 0, 0, '0, '0);
    idle(2);
    chk("wd_no_ack1", 32'(n_ack1 - s1), 32'd0);

    // Randomized traffic with random withdrawals.
    for (int k = 0; k < 2; k++) on[k] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (on[k] && e_ctl[k == 0 ? 5 : 4]) on[k] = 0;
        if (on[k] && $urandom_range(0, 9) == 0) on[k] = 0;
        else if (!on[k] && $urandom_range(0, 1) == 1) begin
          on[k] = 1;
          rwe[k] = 1'($urandom_range(0, 1));
          ra[k] = 13'($urandom_range(0, 31)) ^ ($urandom_range(0, 1) == 1 ? 13'h1FE0 : 13'h0);
          rd[k] = 8'($urandom_range(0, 255));
        end
      end
      cyc(on[0], rwe[0], ra[0], rd[0], on[1], rwe[1], ra[1], rd[1]);
    end
    idle(3);

    // Reset during ISSUE of a write.
    prior = ref_mem[13'h0ABC];
    cyc(0, 0, '0, '0, 1, 1, 13'h0ABC, 8'h77);
    alt_addr = 13'h0ABC; alt_val = prior;
    req1 = 1'b0; we1 = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({ack0, ack1, done0, done1, mem_strobe, mem_write}), 32'h0);
    chk("mid_rst_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_rdata", 32'(rdata), 32'h0);
    m_issue = 0; m_last = 1; e_ctl = '0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_hold", 32'({ack0, ack1, done0, done1, mem_strobe, mem_write}), 32'h0);
    reset_n = 1'b1;
    idle(1);
    cyc(1, 0, 13'h0ABC, '0, 0, 0, '0, '0);
    cyc(0, 0, '0, '0, 0, 0, '0, '0);
    chk("post_rst_done0", 32'(done0), 32'd1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
